// File: rtl/read_axi_splitter_pkg.sv
// Purpose: shared FSM encoding, AXI burst constant and log2 helper for the read splitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package read_axi_splitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Floor log2 for elaboration-time constants (arsize, shift amounts, widths).
    function automatic int log2_int(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) <= value) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/read_axi_chunk_calc.sv
// Purpose: size the next burst: min(remaining, bytes to boundary, MAXLEN beats less start offset).
// Latency: combinational.
// Backpressure: none; the caller registers the result.
// Ports: i_addr current byte address, i_rem bytes still to request (>0),
//        o_chunk bytes in this burst, o_arlen beats-1 for this burst.
module read_axi_chunk_calc
    import read_axi_splitter_pkg::*;
#(
    parameter int AWID     = 32,
    parameter int BUSBYTES = 8,
    parameter int MAXLEN   = 16,
    parameter int BOUNDARY = 4096
) (
    input  logic [AWID-1:0] i_addr,
    input  logic [16:0]     i_rem,
    output logic [16:0]     o_chunk,
    output logic [7:0]      o_arlen
);

    localparam int LOG2B = log2_int(BUSBYTES);
    localparam int BNDW  = log2_int(BOUNDARY) + 1;
    // Wide enough for the remaining count and for the full boundary size.
    localparam int CW    = (BNDW > 17) ? BNDW : 17;

    localparam logic [AWID-1:0] BUS_MASK = AWID'(BUSBYTES - 1);
    localparam logic [AWID-1:0] BND_MASK = AWID'(BOUNDARY - 1);

    logic [CW-1:0] w_off;
    logic [CW-1:0] w_to_bound;
    logic [CW-1:0] w_to_maxlen;
    logic [CW-1:0] w_rem;
    logic [CW-1:0] w_min;
    logic [CW-1:0] w_end;

    assign w_off       = CW'(i_addr & BUS_MASK);
    assign w_to_bound  = CW'(BOUNDARY) - CW'(i_addr & BND_MASK);
    // An unaligned start eats into the first beat, so the byte budget shrinks by the offset.
    assign w_to_maxlen = CW'(MAXLEN * BUSBYTES) - w_off;
    assign w_rem       = CW'(i_rem);

    always_comb begin
        w_min = w_rem;
        if (w_to_bound < w_min) begin
            w_min = w_to_bound;
        end
        if (w_to_maxlen < w_min) begin
            w_min = w_to_maxlen;
        end
    end

    // Last byte position relative to the first beat's aligned base.
    assign w_end   = w_off + w_min - CW'(1);
    assign o_chunk = 17'(w_min);
    assign o_arlen = 8'(w_end >> LOG2B);

endmodule

// File: rtl/read_axi_splitter.sv
// Purpose: split one long read command into boundary/MAXLEN-safe AXI4 INCR AR bursts plus depot records.
// Latency: accept -> CALC -> ISSUE -> arvalid; a further burst costs 2 cycles plus arready wait.
// Backpressure: arvalid rises only when dep_taken=1, then holds stable until arready; cmd_ready=0 while busy.
// Ports: clk/rst (sync, active-high); cmd_* command request; ar* AXI read address channel;
//        dep_* one record per AR handshake towards the read burst depot.
module read_axi_splitter
    import read_axi_splitter_pkg::*;
#(
    parameter int IDWID    = 4,
    parameter int AWID     = 32,
    parameter int BUSBYTES = 8,
    parameter int MAXLEN   = 16,
    parameter int BOUNDARY = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AWID-1:0]  cmd_addr,
    input  logic [IDWID-1:0] cmd_id,
    input  logic [15:0]      cmd_bytes,
    output logic             arvalid,
    input  logic             arready,
    output logic [AWID-1:0]  araddr,
    output logic [IDWID-1:0] arid,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic             dep_arvalid,
    output logic [IDWID-1:0] dep_arid,
    output logic [15:0]      dep_arbytes,
    input  logic             dep_taken
);

    localparam logic [2:0] ARSIZE = 3'(log2_int(BUSBYTES));

    state_t           r_state;
    logic             r_cmd_ready;
    logic [AWID-1:0]  r_addr;
    logic [IDWID-1:0] r_id;
    logic [16:0]      r_rem;
    logic [16:0]      r_chunk;
    logic             r_arvalid;
    logic [AWID-1:0]  r_araddr;
    logic [IDWID-1:0] r_arid;
    logic [7:0]       r_arlen;
    logic [15:0]      r_dep_arbytes;

    logic [16:0]      w_chunk;
    logic [7:0]       w_arlen;
    logic             w_handshake;

    read_axi_chunk_calc #(
        .AWID     (AWID),
        .BUSBYTES (BUSBYTES),
        .MAXLEN   (MAXLEN),
        .BOUNDARY (BOUNDARY)
    ) u_chunk_calc (
        .i_addr  (r_addr),
        .i_rem   (r_rem),
        .o_chunk (w_chunk),
        .o_arlen (w_arlen)
    );

    // arvalid is only ever high in ISSUE, so the handshake alone marks the depot push.
    assign w_handshake = r_arvalid & arready;

    assign cmd_ready   = r_cmd_ready;
    assign arvalid     = r_arvalid;
    assign araddr      = r_araddr;
    assign arid        = r_arid;
    assign arlen       = r_arlen;
    assign arsize      = ARSIZE;
    assign arburst     = AXI_BURST_INCR;
    assign dep_arvalid = w_handshake;
    assign dep_arid    = r_arid;
    assign dep_arbytes = r_dep_arbytes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_addr        <= '0;
            r_id          <= '0;
            r_rem         <= '0;
            r_chunk       <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arid        <= '0;
            r_arlen       <= '0;
            r_dep_arbytes <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_id        <= cmd_id;
                        r_rem       <= {1'b0, cmd_bytes} + 17'd1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_araddr      <= r_addr;
                    r_arid        <= r_id;
                    r_arlen       <= w_arlen;
                    r_chunk       <= w_chunk;
                    r_dep_arbytes <= 16'(w_chunk - 17'd1);
                    r_state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!r_arvalid) begin
                        // Only launch when the depot has room for the matching record.
                        if (dep_taken) begin
                            r_arvalid <= 1'b1;
                        end
                    end else if (arready) begin
                        r_arvalid <= 1'b0;
                        r_addr    <= r_addr + AWID'(r_chunk);
                        r_rem     <= r_rem - r_chunk;
                        if (r_rem == r_chunk) begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_axi_splitter.sv
// Purpose: randomized and directed scoreboard bench for read_axi_splitter.
// Latency: n/a.
// Backpressure: arready/dep_taken driven randomly or by directed sequences.
module tb_read_axi_splitter;

    localparam int IDWID    = 4;
    localparam int AWID     = 32;
    localparam int BUSBYTES = 8;
    localparam int MAXLEN   = 16;
    localparam int BOUNDARY = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [AWID-1:0]  cmd_addr = '0;
    logic [IDWID-1:0] cmd_id = '0;
    logic [15:0]      cmd_bytes = '0;
    logic             arvalid;
    logic             arready = 1'b0;
    logic [AWID-1:0]  araddr;
    logic [IDWID-1:0] arid;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             dep_arvalid;
    logic [IDWID-1:0] dep_arid;
    logic [15:0]      dep_arbytes;
    logic             dep_taken = 1'b0;

    always #5 clk = ~clk;

    read_axi_splitter #(
        .IDWID    (IDWID),
        .AWID     (AWID),
        .BUSBYTES (BUSBYTES),
        .MAXLEN   (MAXLEN),
        .BOUNDARY (BOUNDARY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_id      (cmd_id),
        .cmd_bytes   (cmd_bytes),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddr      (araddr),
        .arid        (arid),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .dep_arvalid (dep_arvalid),
        .dep_arid    (dep_arid),
        .dep_arbytes (dep_arbytes),
        .dep_taken   (dep_taken)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [15:0] bytes;
        bit          last;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;

    // Backpressure control: random percentages or fixed manual levels.
    bit manual  = 1'b0;
    bit man_ar  = 1'b0;
    bit man_dep = 1'b0;
    int p_ar    = 60;
    int p_dep   = 60;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [15:0] bytes, input bit last);
        exp_t e;
        e.addr  = a;
        e.id    = id;
        e.len   = len;
        e.bytes = bytes;
        e.last  = last;
        exp_q.push_back(e);
    endtask

    // Reference model: walk the command byte by byte and close a burst when the
    // next byte would start a new boundary region, or would need beat MAXLEN+1.
    task automatic model_push(input logic [31:0] a, input logic [15:0] b, input logic [3:0] id);
        int          rem;
        int          n;
        int          beats;
        logic [31:0] start;
        logic [31:0] cur;
        logic [31:0] nxt;
        rem   = int'(b) + 1;
        start = a;
        nxt   = a;
        while (rem > 0) begin
            cur   = start;
            n     = 0;
            beats = 1;
            forever begin
                n++;
                rem--;
                nxt = cur + 32'd1;
                if (rem == 0) break;
                if ((nxt % 32'(BOUNDARY)) == 0) break;
                if ((nxt % 32'(BUSBYTES)) == 0) begin
                    if (beats == MAXLEN) break;
                    beats++;
                end
                cur = nxt;
            end
            push_exp(start, id, 8'(beats - 1), 16'(n - 1), rem == 0);
            start = nxt;
        end
    endtask

    // Backpressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (manual) begin
                arready   = man_ar;
                dep_taken = man_dep;
            end else begin
                arready   = ($urandom_range(99) < p_ar);
                dep_taken = ($urandom_range(99) < p_dep);
            end
        end
    end

    // Monitor / scoreboard.
    logic        prev_vld  = 1'b0;
    logic        prev_hs   = 1'b0;
    logic        prev_last = 1'b0;
    logic        prev_dep  = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len  = '0;
    logic [3:0]  prev_id   = '0;
    logic        hs;
    exp_t        me;

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
            prev_hs  = 1'b0;
        end else begin
            hs = arvalid && arready;
            if (prev_hs) begin
                chk("arvalid_after_hs", 64'(arvalid), 64'(0));
                chk("cmd_ready_after_hs", 64'(cmd_ready), 64'(prev_last));
            end else if (prev_vld) begin
                chk("arvalid_hold", 64'(arvalid), 64'(1));
                chk("araddr_hold", 64'(araddr), 64'(prev_addr));
                chk("arlen_hold", 64'(arlen), 64'(prev_len));
                chk("arid_hold", 64'(arid), 64'(prev_id));
            end else if (arvalid) begin
                chk("arvalid_rise_needs_dep_taken", 64'(prev_dep), 64'(1));
            end
            chk("dep_arvalid_eq_handshake", 64'(dep_arvalid), 64'(hs));
            if (hs) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ar: got araddr 0x%0h with empty queue", araddr);
                    prev_last = 1'b0;
                end else begin
                    me = exp_q.pop_front();
                    chk("araddr", 64'(araddr), 64'(me.addr));
                    chk("arid", 64'(arid), 64'(me.id));
                    chk("arlen", 64'(arlen), 64'(me.len));
                    chk("arsize", 64'(arsize), 64'(3));
                    chk("arburst", 64'(arburst), 64'(1));
                    chk("dep_arid", 64'(dep_arid), 64'(me.id));
                    chk("dep_arbytes", 64'(dep_arbytes), 64'(me.bytes));
                    prev_last = me.last;
                end
            end
            prev_vld  = arvalid;
            prev_hs   = hs;
            prev_addr = araddr;
            prev_len  = arlen;
            prev_id   = arid;
            prev_dep  = dep_taken;
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] b, input logic [3:0] id);
        int t;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_bytes = b;
        cmd_id    = id;
        t = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            t++;
            if (t > 50000) begin
                timeout_fail("cmd_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && cmd_ready) break;
            t++;
            if (t > 40000) begin
                timeout_fail("wait_idle");
                exp_q.delete();
                break;
            end
        end
    endtask

    task automatic wait_arvalid();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (arvalid) break;
            t++;
            if (t > 200) begin
                timeout_fail("wait_arvalid");
                break;
            end
        end
    endtask

    // Watchdog.
    initial begin
        repeat (90000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] b;
        int          base;
        int          t;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_dep_arvalid", 64'(dep_arvalid), 64'(0));
        chk("rst_araddr", 64'(araddr), 64'(0));
        chk("rst_arid", 64'(arid), 64'(0));
        chk("rst_arlen", 64'(arlen), 64'(0));
        chk("rst_dep_arbytes", 64'(dep_arbytes), 64'(0));
        chk("rst_arsize", 64'(arsize), 64'(3));
        chk("rst_arburst", 64'(arburst), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single burst.
        push_exp(32'h1000, 4'h1, 8'd15, 16'd127, 1'b1);
        send_cmd(32'h1000, 16'd127, 4'h1);
        wait_idle();

        // 2: multi-burst, with junk commands offered while busy.
        push_exp(32'h1000, 4'h2, 8'd15, 16'd127, 1'b0);
        push_exp(32'h1080, 4'h2, 8'd15, 16'd127, 1'b0);
        push_exp(32'h1100, 4'h2, 8'd5,  16'd43,  1'b1);
        send_cmd(32'h1000, 16'd299, 4'h2);
        repeat (3) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b1;
            cmd_addr  = 32'hDEAD_0000;
            cmd_bytes = 16'd5;
            cmd_id    = 4'hF;
            @(negedge clk);
            chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle();

        // 3: 4KB boundary crossing.
        push_exp(32'h0FF0, 4'h3, 8'd1, 16'd15, 1'b0);
        push_exp(32'h1000, 4'h3, 8'd5, 16'd47, 1'b1);
        send_cmd(32'h0FF0, 16'd63, 4'h3);
        wait_idle();

        // 4: unaligned start.
        push_exp(32'h1003, 4'h4, 8'd15, 16'd124, 1'b0);
        push_exp(32'h1080, 4'h4, 8'd9,  16'd74,  1'b1);
        send_cmd(32'h1003, 16'd199, 4'h4);
        wait_idle();

        // 5: dep_taken low, then arready low.
        @(negedge clk);
        #1;
        manual  = 1'b1;
        man_dep = 1'b0;
        man_ar  = 1'b0;
        push_exp(32'h1000, 4'h5, 8'd15, 16'd127, 1'b1);
        send_cmd(32'h1000, 16'd127, 4'h5);
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("arvalid_wait_dep", 64'(arvalid), 64'(0));
        end
        man_dep = 1'b1;
        wait_arvalid();
        man_dep = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("arvalid_wait_arready", 64'(arvalid), 64'(1));
            chk("dep_quiet_wait_arready", 64'(dep_arvalid), 64'(0));
        end
        man_ar = 1'b1;
        wait_idle();

        // 6: reset while burst 2 is pending.
        man_dep = 1'b1;
        man_ar  = 1'b1;
        base    = n_hs;
        push_exp(32'h1000, 4'h6, 8'd15, 16'd127, 1'b0);
        push_exp(32'h1080, 4'h6, 8'd15, 16'd127, 1'b0);
        push_exp(32'h1100, 4'h6, 8'd5,  16'd43,  1'b1);
        send_cmd(32'h1000, 16'd299, 4'h6);
        t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (n_hs > base) break;
            t++;
            if (t > 200) begin
                timeout_fail("first_hs");
                break;
            end
        end
        man_ar = 1'b0;
        wait_arvalid();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_arvalid", 64'(arvalid), 64'(0));
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("mid_rst_dep_arvalid", 64'(dep_arvalid), 64'(0));
        chk("mid_rst_pending_bursts", 64'(exp_q.size()), 64'(2));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        man_ar = 1'b1;
        push_exp(32'h2000, 4'h7, 8'd0, 16'd7, 1'b1);
        send_cmd(32'h2000, 16'd7, 4'h7);
        wait_idle();

        // Random phase.
        manual = 1'b0;
        p_ar   = 70;
        p_dep  = 70;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(2))
                0:       a = $urandom;
                1:       a = ($urandom & 32'hFFFF_F000) - 32'($urandom_range(1, 200));
                default: a = 32'($urandom_range(0, 255));
            endcase
            if ($urandom_range(3) == 0) b = 16'($urandom_range(0, 15));
            else                        b = 16'($urandom_range(0, 3000));
            model_push(a, b, 4'($urandom_range(15)));
            send_cmd(a, b, exp_q[0].id);
            wait_idle();
        end

        // Address wrap and maximum-size command.
        model_push(32'hFFFF_FFF0, 16'd31, 4'h9);
        send_cmd(32'hFFFF_FFF0, 16'd31, 4'h9);
        wait_idle();
        p_ar  = 100;
        p_dep = 100;
        model_push(32'h0000_0F05, 16'hFFFF, 4'hA);
        send_cmd(32'h0000_0F05, 16'hFFFF, 4'hA);
        wait_idle();

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
